// File: rtl/serial_frame_transmitter_if.sv
// Parallel-load / serial-out bundle between a word producer and the
// serial frame transmitter. The producer side is the master.
interface serial_frame_transmitter_if #(
   parameter int WIDTH = 4
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] data_in;
   logic             shift_dir;
   logic             shift_en;
   logic             data_out_serial;
   logic             serial_valid;
   logic             frame_last;
   logic             busy;
   logic [7:0]       frames_sent;

   modport master (
      output load_valid, data_in, shift_dir, shift_en,
      input  load_ready, data_out_serial, serial_valid, frame_last, busy, frames_sent
   );

   modport slave (
      input  load_valid, data_in, shift_dir, shift_en,
      output load_ready, data_out_serial, serial_valid, frame_last, busy, frames_sent
   );
endinterface

// File: rtl/serial_frame_transmitter.sv
// Serial frame transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per shift_en tick, LSB or MSB first,
// followed by GAP_BITS ticks of idle level.
module serial_frame_transmitter #(
   parameter int   WIDTH      = 4,
   parameter int   GAP_BITS   = 1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input logic                      clock,
   input logic                      reset,
   serial_frame_transmitter_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam int CW = $clog2(WIDTH);
   localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

   logic [1:0]       state_q,   state_d;
   logic [WIDTH-1:0] sreg_q,    sreg_d;
   logic             dir_q,     dir_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [7:0]       frames_q,  frames_d;

   logic in_shift;
   logic bit_take;
   logic bit_last;

   // A bit is consumed on any SHIFT cycle with a tick; the final one closes the frame.
   assign in_shift = (state_q == S_SHIFT);
   assign bit_take = in_shift & bus.shift_en;
   assign bit_last = bit_take & (bit_cnt_q == CW'(WIDTH - 1));

   // The serial line shows the outgoing end of the shift register for the captured direction.
   assign bus.data_out_serial = in_shift ? (dir_q ? sreg_q[0] : sreg_q[WIDTH-1]) : IDLE_LEVEL;
   assign bus.serial_valid    = bit_take;
   assign bus.frame_last      = bit_last;
   assign bus.load_ready      = (state_q == S_IDLE);
   assign bus.busy            = (state_q != S_IDLE);
   assign bus.frames_sent     = frames_q;

   // Next-state logic for the frame sequencer, shift register and counters.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      dir_d     = dir_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      frames_d  = frames_q;
      case (state_q)
         S_IDLE: begin
            if (bus.load_valid) begin
               sreg_d    = bus.data_in;
               dir_d     = bus.shift_dir;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bit_take) begin
               sreg_d    = dir_q ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (bit_last) begin
                  frames_d  = frames_q + 8'd1;
                  bit_cnt_d = '0;
                  gap_cnt_d = '0;
                  state_d   = (GAP_BITS > 0) ? S_GAP : S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (bus.shift_en) begin
               if (gap_cnt_q == GW'(GAP_BITS - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + GW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any frame in flight without counting it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         sreg_q    <= '0;
         dir_q     <= 1'b0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         frames_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         dir_q     <= dir_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         frames_q  <= frames_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Self-checking bench for serial_frame_transmitter: a bit-queue reference
// model checked every cycle, directed scenarios with literal expectations,
// and a randomized phase.
module tb_serial_frame_transmitter;

   localparam int   WIDTH      = 4;
   localparam int   GAP_BITS   = 1;
   localparam logic IDLE_LEVEL = 1'b0;

   logic clock = 1'b0;
   logic reset = 1'b0;

   serial_frame_transmitter_if #(.WIDTH(WIDTH)) bus ();

   serial_frame_transmitter #(
      .WIDTH(WIDTH), .GAP_BITS(GAP_BITS), .IDLE_LEVEL(IDLE_LEVEL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: the bits still to be sent, in wire order, plus idle ticks left.
   bit         m_q[$];
   int         m_gap;
   logic [7:0] m_frames;
   int         m_accepts;

   logic [WIDTH-1:0] rx_r, rx_l;
   int nval;
   int last_at;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_gap    = 0;
      m_frames = 8'd0;
   endfunction

   task automatic check_outputs();
      bit rdy;
      rdy = (m_q.size() == 0) && (m_gap == 0);
      chk("load_ready",      {31'd0, bus.load_ready},      {31'd0, rdy});
      chk("busy",            {31'd0, bus.busy},            {31'd0, !rdy});
      chk("serial_valid",    {31'd0, bus.serial_valid},    {31'd0, (m_q.size() > 0) && bus.shift_en});
      chk("data_out_serial", {31'd0, bus.data_out_serial}, {31'd0, (m_q.size() > 0) ? logic'(m_q[0]) : IDLE_LEVEL});
      chk("frame_last",      {31'd0, bus.frame_last},      {31'd0, (m_q.size() == 1) && bus.shift_en});
      chk("frames_sent",     {24'd0, bus.frames_sent},     {24'd0, m_frames});
   endtask

   // Advance the model across one rising edge using the inputs held before it.
   task automatic model_edge();
      bit acc;
      acc = (m_q.size() == 0) && (m_gap == 0) && bus.load_valid;
      if (bus.shift_en) begin
         if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
               m_frames = m_frames + 8'd1;
               m_gap    = GAP_BITS;
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end
      end
      if (acc) begin
         for (int k = 0; k < WIDTH; k++)
            m_q.push_back(bus.shift_dir ? bus.data_in[k] : bus.data_in[WIDTH-1-k]);
         m_accepts++;
      end
   endtask

   // One clock: check mid-cycle, record received bits, cross the edge, update the model.
   task automatic cyc();
      #1;
      check_outputs();
      if (bus.serial_valid === 1'b1) begin
         rx_r = {bus.data_out_serial, rx_r[WIDTH-1:1]};
         rx_l = {rx_l[WIDTH-2:0], bus.data_out_serial};
         nval++;
         if (bus.frame_last === 1'b1) last_at = nval;
      end
      @(posedge clock);
      if (reset) model_edge();
      #1;
   endtask

   task automatic clr_rx();
      rx_r = '0; rx_l = '0; nval = 0; last_at = 0;
   endtask

   task automatic async_reset_check(input string tag);
      reset = 1'b0;
      model_reset();
      #2;
      chk({tag, "_ready"},  {31'd0, bus.load_ready},      32'd1);
      chk({tag, "_busy"},   {31'd0, bus.busy},            32'd0);
      chk({tag, "_dout"},   {31'd0, bus.data_out_serial}, {31'd0, IDLE_LEVEL});
      chk({tag, "_valid"},  {31'd0, bus.serial_valid},    32'd0);
      chk({tag, "_frames"}, {24'd0, bus.frames_sent},     32'd0);
      reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end

   initial begin
      int base, n;
      bus.load_valid = 1'b0;
      bus.data_in    = '0;
      bus.shift_dir  = 1'b0;
      bus.shift_en   = 1'b0;
      m_accepts      = 0;
      model_reset();
      clr_rx();
      repeat (2) cyc();
      reset = 1'b1;
      cyc();

      // Reset two bits into a frame, asserted between clock edges.
      bus.load_valid = 1'b1; bus.data_in = 4'h5; bus.shift_dir = 1'b1; bus.shift_en = 1'b1;
      cyc();
      bus.load_valid = 1'b0;
      repeat (2) cyc();
      async_reset_check("midframe_reset");
      cyc();

      // 4'b1011 LSB first into a right-shift receiver.
      clr_rx();
      bus.load_valid = 1'b1; bus.data_in = 4'b1011; bus.shift_dir = 1'b1; bus.shift_en = 1'b1;
      cyc();
      bus.load_valid = 1'b0; bus.data_in = 4'h0; bus.shift_dir = 1'b0;
      repeat (4) cyc();
      chk("lsb_first_rx", {28'd0, rx_r}, 32'hB);
      chk("lsb_first_nbits", nval, 4);
      chk("lsb_first_last", last_at, 4);
      cyc();
      chk("lsb_first_ready", {31'd0, bus.load_ready}, 32'd1);
      chk("lsb_first_frames", {24'd0, bus.frames_sent}, 32'd1);

      // Same word MSB first into a left-shift receiver.
      clr_rx();
      bus.load_valid = 1'b1; bus.data_in = 4'b1011; bus.shift_dir = 1'b0;
      cyc();
      bus.load_valid = 1'b0; bus.shift_dir = 1'b1;
      repeat (5) cyc();
      chk("msb_first_rx", {28'd0, rx_l}, 32'hB);
      chk("msb_first_frames", {24'd0, bus.frames_sent}, 32'd2);

      async_reset_check("counted_reset");
      cyc();

      // shift_en toggling: four bits over eight cycles.
      clr_rx();
      bus.load_valid = 1'b1; bus.data_in = 4'h6; bus.shift_dir = 1'b1; bus.shift_en = 1'b1;
      cyc();
      bus.load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.shift_en = (i % 2 == 0);
         cyc();
      end
      chk("toggle_pulses", nval, 4);
      chk("toggle_rx", {28'd0, rx_r}, 32'h6);
      bus.shift_en = 1'b1;
      repeat (2) cyc();

      // Word offered while busy is held off, then accepted when ready returns.
      clr_rx();
      bus.load_valid = 1'b1; bus.data_in = 4'h3; bus.shift_dir = 1'b1; bus.shift_en = 1'b1;
      cyc();
      bus.data_in = 4'hF;
      repeat (4) cyc();
      chk("busy_hold_first", {28'd0, rx_r}, 32'h3);
      repeat (2) cyc();
      bus.load_valid = 1'b0;
      repeat (4) cyc();
      chk("busy_hold_second", {28'd0, rx_r}, 32'hF);
      repeat (2) cyc();
      chk("busy_hold_frames", {24'd0, bus.frames_sent}, 32'd3);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bus.load_valid = ($urandom_range(0, 3) != 0);
         bus.data_in    = WIDTH'($urandom);
         bus.shift_dir  = $urandom_range(0, 1) != 0;
         bus.shift_en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b0;
            model_reset();
         end
         cyc();
         reset = 1'b1;
      end

      // 256 back-to-back frames wrap the counter to zero.
      reset = 1'b0;
      model_reset();
      cyc();
      reset = 1'b1;
      bus.load_valid = 1'b1; bus.shift_en = 1'b1;
      base = m_accepts;
      n = 0;
      while ((m_accepts - base) < 256 && n < 3000) begin
         bus.data_in   = WIDTH'($urandom);
         bus.shift_dir = $urandom_range(0, 1) != 0;
         cyc();
         n++;
      end
      bus.load_valid = 1'b0;
      chk("wrap_accepts_in_budget", {31'd0, (m_accepts - base) == 256}, 32'd1);
      n = 0;
      cyc();
      while (bus.load_ready !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk("wrap_idle", {31'd0, bus.load_ready}, 32'd1);
      chk("wrap_frames", {24'd0, bus.frames_sent}, 32'd0);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
